// File: rtl/alu_mul_seq.sv
// alu_mul_seq: multi-cycle shift-add multiplier sequencing the shared ALU, low N bits of the product.
// Define SIGNED_MUL_EN for two's-complement operands (adds NEGA/NEGB/NEGP states).
module alu_mul_seq #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] product,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [3:0]   alu_sel,
    input  logic [N-1:0] alu_result,
    input  logic         alu_z
);
    localparam logic [3:0] SEL_ADD = 4'b0001;
    localparam logic [3:0] SEL_SHL = 4'b0011;
    localparam logic [3:0] SEL_SHR = 4'b0100;
    localparam logic [3:0] SEL_PASS = 4'b1000;
`ifdef SIGNED_MUL_EN
    localparam logic [3:0] SEL_SUB = 4'b0010;
    typedef enum logic [3:0] {IDLE, TEST, ADD, SHL, SHR, DONE, NEGA, NEGB, NEGP} state_t;
    logic s_q, s_d;
`else
    typedef enum logic [2:0] {IDLE, TEST, ADD, SHL, SHR, DONE} state_t;
`endif
    state_t state_q, state_d;
    logic [N-1:0] m_q, m_d, q_q, q_d, p_q, p_d, product_q, product_d;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign product = product_q;
    always_comb begin
        state_d = state_q;
        m_d = m_q;
        q_d = q_q;
        p_d = p_q;
        product_d = product_q;
        alu_a = '0;
        alu_b = '0;
        alu_sel = 4'b0000;
`ifdef SIGNED_MUL_EN
        s_d = s_q;
`endif
        case (state_q)
            IDLE: if (start) begin
                m_d = op_a;
                q_d = op_b;
                p_d = '0;
`ifdef SIGNED_MUL_EN
                s_d = op_a[N-1] ^ op_b[N-1];
                state_d = op_a[N-1] ? NEGA : op_b[N-1] ? NEGB : TEST;
`else
                state_d = TEST;
`endif
            end
            TEST: begin
                alu_a = q_q;
                alu_sel = SEL_PASS;
`ifdef SIGNED_MUL_EN
                state_d = alu_z ? (s_q ? NEGP : DONE) : q_q[0] ? ADD : SHL;
                product_d = (alu_z && !s_q) ? p_q : product_q;
`else
                state_d = alu_z ? DONE : q_q[0] ? ADD : SHL;
                product_d = alu_z ? p_q : product_q;
`endif
            end
            ADD: begin
                alu_a = p_q;
                alu_b = m_q;
                alu_sel = SEL_ADD;
                p_d = alu_result;
                state_d = SHL;
            end
            SHL: begin
                alu_a = m_q;
                alu_b = N'(1);
                alu_sel = SEL_SHL;
                m_d = alu_result;
                state_d = SHR;
            end
            SHR: begin
                alu_a = q_q;
                alu_b = N'(1);
                alu_sel = SEL_SHR;
                q_d = alu_result;
                state_d = TEST;
            end
`ifdef SIGNED_MUL_EN
            NEGA: begin
                alu_b = m_q;
                alu_sel = SEL_SUB;
                m_d = alu_result;
                state_d = q_q[N-1] ? NEGB : TEST;
            end
            NEGB: begin
                alu_b = q_q;
                alu_sel = SEL_SUB;
                q_d = alu_result;
                state_d = TEST;
            end
            NEGP: begin
                alu_b = p_q;
                alu_sel = SEL_SUB;
                p_d = alu_result;
                product_d = alu_result;
                state_d = DONE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q <= '0;
            q_q <= '0;
            p_q <= '0;
            product_q <= '0;
`ifdef SIGNED_MUL_EN
            s_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            m_q <= m_d;
            q_q <= q_d;
            p_q <= p_d;
            product_q <= product_d;
`ifdef SIGNED_MUL_EN
            s_q <= s_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: drives alu_mul_seq with a behavioural ALU, checks products and busy/done timing.
module tb_alu_mul_seq;
    logic        clk, rst, start, busy, done, alu_z;
    logic [31:0] op_a, op_b, product, alu_a, alu_b, alu_result;
    logic [3:0]  alu_sel;
    int total = 0;
    int bad = 0;

    alu_mul_seq #(.N(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy), .done(done), .product(product),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_z(alu_z)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            4'b0001: alu_result = alu_a + alu_b;
            4'b0010: alu_result = alu_a - alu_b;
            4'b0011: alu_result = alu_a << alu_b;
            4'b0100: alu_result = alu_a >> alu_b;
            4'b1000: alu_result = alu_a;
            default: alu_result = '0;
        endcase
    end
    assign alu_z = alu_result == 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected busy span: each multiplier bit up to its MSB costs 4 (one) or 3 (zero), plus final TEST and DONE.
    function automatic int exp_cycles(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        int c;
        m = b;
        c = 2;
`ifdef SIGNED_MUL_EN
        if (b[31]) m = -b;
        c += int'(a[31]) + int'(b[31]) + int'(a[31] ^ b[31]);
`endif
        while (m != 0) begin
            c += m[0] ? 4 : 3;
            m = m >> 1;
        end
        return c;
    endfunction

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int inj);
        logic [31:0] exp_p;
        int exp_c, cyc, ndone, done_at;
        exp_p = a * b;
        exp_c = exp_cycles(a, b);
        @(negedge clk);
        start = 1;
        op_a = a;
        op_b = b;
        @(negedge clk);
        start = 0;
        cyc = 0;
        ndone = 0;
        done_at = 0;
        while (busy === 1'b1 && cyc < 300) begin
            cyc++;
            if (done === 1'b1) begin
                ndone++;
                done_at = cyc;
                check("product_in_done", product, exp_p);
            end
            if (cyc == inj) begin
                start = 1;
                op_a = 32'd1;
                op_b = 32'd1;
            end else start = 0;
            @(negedge clk);
        end
        start = 0;
        check("busy_span", 32'(cyc), 32'(exp_c));
        check("done_count", 32'(ndone), 32'd1);
        check("done_last_cycle", 32'(done_at), 32'(exp_c));
        check("product_held", product, exp_p);
    endtask

    initial begin
        rst = 1;
        start = 0;
        op_a = '0;
        op_b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_alu_sel", {28'd0, alu_sel}, 32'd0);
        rst = 0;
        run_mul(32'd7, 32'd6, 0);
        run_mul(32'h12345678, 32'd0, 0);
        run_mul(32'hFFFFFFFF, 32'd2, 0);
        run_mul(32'd7, 32'd6, 3);
        // Reset during the first ADD cycle of 7*6 (TEST, SHL, SHR, TEST, ADD).
        @(negedge clk);
        start = 1;
        op_a = 32'd7;
        op_b = 32'd6;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        check("add_cycle_sel", {28'd0, alu_sel}, 32'd1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_product", product, 32'd0);
        check("abort_alu_sel", {28'd0, alu_sel}, 32'd0);
        run_mul(32'd5, 32'd3, 0);
        // start together with rst must be dropped.
        @(negedge clk);
        start = 1;
        rst = 1;
        @(negedge clk);
        start = 0;
        rst = 0;
        check("rst_wins_busy", {31'd0, busy}, 32'd0);
        check("rst_wins_product", product, 32'd0);
`ifdef SIGNED_MUL_EN
        run_mul(32'hFFFFFFFD, 32'd5, 0);
        run_mul(32'hFFFFFFFC, 32'hFFFFFFFC, 0);
`endif
        for (int i = 0; i < 8; i++) run_mul($urandom, $urandom >> $urandom_range(0, 31), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
